// File: rtl/ram_dumper.sv
// Purpose : reads the program RAM back over the shared CPU bus, one byte per host valid/ack handshake.
// Latency : start rise -> first data_valid 3 clk; ack rise -> next data_valid 4 clk; last ack -> done 2 clk.
// Backpress: holds each byte in PRESENT until a fresh ack rise; ack levels or early acks are not remembered.
//
// Ports:
//   clk, resetn      system clock, synchronous active-low reset
//   start            dump request (rising edge, ignored while busy)
//   ack              host acknowledge (rising edge, only counted in PRESENT)
//   bus              shared CPU bus, driven with the RAM address during ADDR only
//   ctrl             15-bit CPU control word (mixed-polarity strobes)
//   data_out         last captured RAM byte, addr_out its address
//   data_valid       data_out holds an unacknowledged byte
//   busy / done      dump in progress / all addresses dumped
module ram_dumper #(
    parameter int          ADDR_W    = 4,
    parameter int          DATA_W    = 8,
    parameter logic [14:0] IDLE_CTRL = 15'b000111111100011
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic              ack,
    inout  wire  [DATA_W-1:0] bus,
    output logic [14:0]       ctrl,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic [ADDR_W-1:0] addr_out,
    output logic              busy,
    output logic              done
);

    // Active-low strobes used by the dumper; every other bit stays at its idle level.
    localparam int MAR_ADDR_LOAD_N = 11;
    localparam int RAM_EN_N        = 9;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_READ,
        S_PRESENT,
        S_NEXT,
        S_DONE
    } state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data_reg;
    logic              start_d, ack_d;
    logic              start_rise, ack_rise;
    logic              addr_clr, addr_inc, capture, bus_drive;

    assign start_rise = start & ~start_d;
    assign ack_rise   = ack & ~ack_d;

    // Address zero-extended onto the bus so the upper bits read as 0.
    assign bus      = bus_drive ? DATA_W'(addr) : {DATA_W{1'bz}};
    assign data_out = data_reg;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state    <= S_IDLE;
            addr     <= '0;
            data_reg <= '0;
            addr_out <= '0;
            start_d  <= 1'b0;
            ack_d    <= 1'b0;
        end else begin
            state   <= state_nxt;
            start_d <= start;
            ack_d   <= ack;
            if (addr_clr) begin
                addr <= '0;
            end else if (addr_inc) begin
                addr <= addr + ADDR_W'(1);
            end
            if (capture) begin
                data_reg <= bus;
                addr_out <= addr;
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        ctrl       = IDLE_CTRL;
        data_valid = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        addr_clr   = 1'b0;
        addr_inc   = 1'b0;
        capture    = 1'b0;
        bus_drive  = 1'b0;

        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start_rise) begin
                    addr_clr  = 1'b1;
                    state_nxt = S_ADDR;
                end
            end
            S_ADDR: begin
                bus_drive             = 1'b1;
                ctrl[MAR_ADDR_LOAD_N] = 1'b0;
                state_nxt             = S_READ;
            end
            S_READ: begin
                // RAM drives the bus here; the byte is taken on the exit edge.
                ctrl[RAM_EN_N] = 1'b0;
                capture        = 1'b1;
                state_nxt      = S_PRESENT;
            end
            S_PRESENT: begin
                data_valid = 1'b1;
                if (ack_rise) begin
                    state_nxt = S_NEXT;
                end
            end
            S_NEXT: begin
                // Stop at the top address rather than wrapping back to 0.
                if (&addr) begin
                    state_nxt = S_DONE;
                end else begin
                    addr_inc  = 1'b1;
                    state_nxt = S_ADDR;
                end
            end
            S_DONE: begin
                busy = 1'b0;
                done = 1'b1;
                if (start_rise) begin
                    addr_clr  = 1'b1;
                    state_nxt = S_ADDR;
                end
            end
            default: begin
                busy      = 1'b0;
                state_nxt = S_IDLE;
            end
        endcase
    end

endmodule
